// File: rtl/video_cap_pkg.sv
// Shared types and widths for the DVP camera capture path.
package video_cap_pkg;

  localparam int unsigned X_W = 12;
  localparam int unsigned Y_W = 11;

  typedef enum logic [1:0] {
    S_SKIP,
    S_IDLE,
    S_SYNC,
    S_ACTIVE
  } cap_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Combine the two bytes of a pixel; first is the byte that arrived first on the bus.
  function automatic rgb565_t pair_bytes(input logic [7:0] first, input logic [7:0] second,
                                         input bit hi_first);
    return rgb565_t'(hi_first ? {first, second} : {second, first});
  endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// Two-stage register for camera sync lines; presents the first-stage level plus
// single-cycle rise/fall strobes derived from stage 1 against stage 2.
module dvp_sync_edge #(
  parameter int unsigned W = 2
) (
  input  logic         I_clk,
  input  logic         I_rst,
  input  logic [W-1:0] I_sig,
  output logic [W-1:0] O_level,
  output logic [W-1:0] O_rise,
  output logic [W-1:0] O_fall
);

  logic [W-1:0] d1_q;
  logic [W-1:0] d2_q;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d1_q <= I_sig;
      d2_q <= d1_q;
    end
  end

  always_comb begin
    O_level = d1_q;
    O_rise  = d1_q & ~d2_q;
    O_fall  = ~d1_q & d2_q;
  end

endmodule

// File: rtl/dvp_rgb565_capture.sv
// OV2640 DVP capture: skips settling frames, pairs bytes into RGB565, crops a window
// and drives frame-buffer vs_n/de/data, with frame counting and malformed-input flags.
module dvp_rgb565_capture
  import video_cap_pkg::*;
#(
  parameter int unsigned H_RES       = 1024,
  parameter int unsigned V_RES       = 768,
  parameter int unsigned H_START     = 0,
  parameter int unsigned V_START     = 0,
  parameter int unsigned SKIP_FRAMES = 2,
  parameter bit          HI_FIRST    = 1'b1,
  parameter bit          VS_POL      = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_enable,
  input  logic        I_vsync,
  input  logic        I_href,
  input  logic [7:0]  I_data,
  output logic        O_vs_n,
  output logic        O_de,
  output logic [15:0] O_data,
  output logic [15:0] O_frame_cnt,
  output logic        O_line_err,
  output logic        O_frame_err
);

  localparam logic [X_W-1:0] XStart   = X_W'(H_START);
  localparam logic [X_W-1:0] XRes     = X_W'(H_RES);
  localparam logic [X_W-1:0] XEnd     = X_W'(H_START + H_RES);
  localparam logic [Y_W-1:0] YStart   = Y_W'(V_START);
  localparam logic [Y_W-1:0] YRes     = Y_W'(V_RES);
  localparam logic [Y_W-1:0] YEnd     = Y_W'(V_START + V_RES);
  localparam logic [15:0]    SkipLast = 16'(SKIP_FRAMES - 1);

  logic [1:0] sync_level, sync_rise, sync_fall;
  logic       vs_rise, vs_fall, href_level, href_fall;
  logic [7:0] data_d1_q;

  dvp_sync_edge #(
    .W(2)
  ) u_sync_edge (
    .I_clk  (I_clk),
    .I_rst  (I_rst),
    .I_sig  ({(I_vsync == VS_POL), I_href}),
    .O_level(sync_level),
    .O_rise (sync_rise),
    .O_fall (sync_fall)
  );

  assign vs_rise    = sync_rise[1];
  assign vs_fall    = sync_fall[1];
  assign href_level = sync_level[0];
  assign href_fall  = sync_fall[0];

  cap_state_e     state_q, state_d;
  logic [15:0]    skip_cnt_q, skip_cnt_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           phase_q, phase_d;
  logic [7:0]     byte_q, byte_d;
  logic           de_q, de_d;
  rgb565_t        data_q, data_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           line_err_q, line_err_d;
  logic           frame_err_q, frame_err_d;

  logic [X_W-1:0] x_inc, x_off;
  logic [Y_W-1:0] y_inc, y_off, y_line;
  logic           in_win;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      data_d1_q   <= '0;
      state_q     <= S_SKIP;
      skip_cnt_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      byte_q      <= '0;
      de_q        <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_d1_q   <= I_data;
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      byte_q      <= byte_d;
      de_q        <= de_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Offsets wrap when below the window start, so one unsigned compare covers both bounds.
  always_comb begin
    x_inc  = (x_q == '1) ? x_q : x_q + X_W'(1);
    y_inc  = (y_q == '1) ? y_q : y_q + Y_W'(1);
    x_off  = x_q - XStart;
    y_off  = y_q - YStart;
    in_win = (x_off < XRes) && (y_off < YRes);
  end

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = 1'b0;
    byte_d      = byte_q;
    de_d        = 1'b0;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    y_line      = y_q;

    unique case (state_q)
      S_SKIP: begin
        if (SKIP_FRAMES == 0) begin
          state_d = S_IDLE;
        end else if (vs_rise) begin
          if (skip_cnt_q == SkipLast) begin
            state_d    = S_IDLE;
            skip_cnt_d = '0;
          end else begin
            skip_cnt_d = skip_cnt_q + 16'd1;
          end
        end
      end
      S_IDLE: begin
        if (vs_rise && I_enable) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (vs_fall) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (href_level) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            byte_d = data_d1_q;
          end else begin
            // A pixel coinciding with frame end is dropped so de never overlaps vs_n low.
            if (in_win && !vs_rise) begin
              de_d   = 1'b1;
              data_d = pair_bytes(byte_q, data_d1_q, HI_FIRST);
            end
            x_d = x_inc;
          end
        end
        if (href_fall) begin
          y_line = y_inc;
          x_d    = '0;
          if (phase_q || (x_q < XEnd)) line_err_d = 1'b1;
        end
        y_d = y_line;
        if (vs_rise) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (y_line < YEnd) frame_err_d = 1'b1;
          state_d = I_enable ? S_SYNC : S_IDLE;
        end
      end
      default: state_d = S_SKIP;
    endcase
  end

  always_comb begin
    O_vs_n      = (state_q != S_SYNC);
    O_de        = de_q;
    O_data      = data_q;
    O_frame_cnt = frame_cnt_q;
    O_line_err  = line_err_q;
    O_frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Scoreboard bench: stimulus pushes expected pixels with their byte cycle; a monitor
// pops on every O_de and checks value, byte order (HI_FIRST=0 twin) and latency.
module tb_dvp_rgb565_capture;

  localparam int unsigned HS = 4;
  localparam int unsigned HR = 8;
  localparam int unsigned VS = 2;
  localparam int unsigned VR = 3;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_enable = 1'b0;
  logic        I_vsync = 1'b0;
  logic        I_href = 1'b0;
  logic [7:0]  I_data = 8'h00;
  logic        O_vs_n, O_de, O_line_err, O_frame_err;
  logic [15:0] O_data, O_frame_cnt;
  logic        lo_vs_n, lo_de, lo_line_err, lo_frame_err;
  logic [15:0] lo_data, lo_frame_cnt;

  dvp_rgb565_capture #(
    .H_RES(HR), .V_RES(VR), .H_START(HS), .V_START(VS),
    .SKIP_FRAMES(2), .HI_FIRST(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_enable(I_enable), .I_vsync(I_vsync),
    .I_href(I_href), .I_data(I_data), .O_vs_n(O_vs_n), .O_de(O_de), .O_data(O_data),
    .O_frame_cnt(O_frame_cnt), .O_line_err(O_line_err), .O_frame_err(O_frame_err)
  );

  dvp_rgb565_capture #(
    .H_RES(HR), .V_RES(VR), .H_START(HS), .V_START(VS),
    .SKIP_FRAMES(2), .HI_FIRST(1'b0), .VS_POL(1'b1)
  ) u_dut_lo (
    .I_clk(I_clk), .I_rst(I_rst), .I_enable(I_enable), .I_vsync(I_vsync),
    .I_href(I_href), .I_data(I_data), .O_vs_n(lo_vs_n), .O_de(lo_de), .O_data(lo_data),
    .O_frame_cnt(lo_frame_cnt), .O_line_err(lo_line_err), .O_frame_err(lo_frame_err)
  );

  always #5 I_clk = ~I_clk;

  int unsigned cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] pix;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned de_total = 0;
  int unsigned vs_low_cnt = 0;
  int unsigned vs_fall_cyc = 0;
  logic [15:0] log_hi[0:511];
  logic [15:0] log_lo[0:511];
  bit          stim_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  function automatic logic [15:0] pix_val(input int x, input int y, input int fid);
    if (fid == 4 && x == 4 && y == 2) return 16'hF81F;
    return {4'(y), 4'(x), 8'(fid)};
  endfunction

  function automatic bit in_window(input int x, input int y);
    return (x >= HS) && (x < HS + HR) && (y >= VS) && (y < VS + VR);
  endfunction

  task automatic drive_byte(input int b, input int y, input int fid, input bit cap);
    logic [15:0] p;
    exp_t e;
    p = pix_val(b / 2, y, fid);
    @(negedge I_clk);
    I_href = 1'b1;
    I_data = (b % 2 == 0) ? p[15:8] : p[7:0];
    if (cap && (b % 2 == 1) && in_window(b / 2, y)) begin
      e.pix = p;
      e.due = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic line_gap();
    @(negedge I_clk);
    I_href = 1'b0;
    I_data = 8'h00;
    repeat (3) @(negedge I_clk);
  endtask

  task automatic send_line(input int nbytes, input int y, input int fid, input bit cap);
    for (int b = 0; b < nbytes; b++) drive_byte(b, y, fid, cap);
    line_gap();
  endtask

  task automatic send_frame(input int fid, input bit cap);
    for (int y = 0; y < 8; y++) send_line(32, y, fid, cap);
  endtask

  task automatic vsync_pulse(input bit expect_sync);
    int unsigned t0, c0;
    c0 = vs_low_cnt;
    @(negedge I_clk);
    I_vsync = 1'b1;
    t0 = cyc;
    repeat (4) @(negedge I_clk);
    I_vsync = 1'b0;
    repeat (4) @(negedge I_clk);
    if (expect_sync) begin
      check("vs_n_fall_latency", vs_fall_cyc, t0 + 2);
      check("vs_n_low_once", vs_low_cnt, c0 + 1);
    end else begin
      check("vs_n_stays_high", vs_low_cnt, c0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vs_n"}, O_vs_n, 1);
    check({tag, "_de"}, O_de, 0);
    check({tag, "_data"}, O_data, 0);
    check({tag, "_frame_cnt"}, O_frame_cnt, 0);
    check({tag, "_line_err"}, O_line_err, 0);
    check({tag, "_frame_err"}, O_frame_err, 0);
  endtask

  initial begin
    fork
      begin : monitor
        bit   prev_vs_n;
        exp_t e;
        prev_vs_n = 1'b1;
        while (!stim_done) begin
          @(negedge I_clk);
          if (prev_vs_n && !O_vs_n) begin
            vs_fall_cyc = cyc;
            vs_low_cnt++;
          end
          prev_vs_n = O_vs_n;
          if (O_de || lo_de) begin
            check("de_twin_agree", lo_de, O_de);
            check("de_outside_vs", O_vs_n, 1);
          end
          if (O_de) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_de: got pixel %h, required no pixel (cycle %0d)",
                       O_data, cyc);
            end else begin
              e = exp_q.pop_front();
              check("pixel_hi_first", O_data, e.pix);
              check("pixel_lo_first", lo_data, {e.pix[7:0], e.pix[15:8]});
              check("pixel_latency", cyc, e.due + 2);
            end
            if (de_total < 512) begin
              log_hi[de_total] = O_data;
              log_lo[de_total] = lo_data;
            end
            de_total++;
          end
        end
      end
      begin : stimulus
        repeat (3) @(negedge I_clk);
        check_reset_vals("reset");
        I_rst = 1'b0;
        I_enable = 1'b1;
        repeat (2) @(negedge I_clk);

        // Frames 1-2 are discarded for camera settling
        vsync_pulse(1'b0);
        send_frame(1, 1'b0);
        vsync_pulse(1'b0);
        send_frame(2, 1'b0);
        check("skip_no_pixels", de_total, 0);

        vsync_pulse(1'b1);
        send_frame(3, 1'b1);
        check("f3_pixel_count", de_total, 24);
        check("f3_first_pixel", log_hi[0], 16'h2403);
        vsync_pulse(1'b1);
        check("cnt_after_f3", O_frame_cnt, 1);

        send_frame(4, 1'b1);
        check("f4_byte_order_hi", log_hi[24], 16'hF81F);
        check("f4_byte_order_lo", log_lo[24], 16'h1FF8);
        vsync_pulse(1'b1);
        check("cnt_after_f4", O_frame_cnt, 2);

        // Drop enable halfway: frame 5 must still complete
        for (int y = 0; y < 4; y++) send_line(32, y, 5, 1'b1);
        I_enable = 1'b0;
        for (int y = 4; y < 8; y++) send_line(32, y, 5, 1'b1);
        check("f5_full_frame", de_total, 72);
        vsync_pulse(1'b0);
        check("cnt_after_f5", O_frame_cnt, 3);
        send_frame(6, 1'b0);
        vsync_pulse(1'b0);
        send_frame(7, 1'b0);
        check("disabled_no_pixels", de_total, 72);
        check("cnt_while_disabled", O_frame_cnt, 3);

        I_enable = 1'b1;
        vsync_pulse(1'b1);
        check("cnt_on_resume", O_frame_cnt, 3);
        send_frame(8, 1'b1);
        check("f8_resumed", de_total, 96);
        vsync_pulse(1'b1);
        check("cnt_after_f8", O_frame_cnt, 4);

        // Reset mid-pair on a cropped line
        send_line(32, 0, 9, 1'b1);
        send_line(32, 1, 9, 1'b1);
        for (int b = 0; b < 13; b++) drive_byte(b, 2, 9, 1'b1);
        check("clean_line_err", O_line_err, 0);
        check("clean_frame_err", O_frame_err, 0);
        @(negedge I_clk);
        I_rst = 1'b1;
        I_data = 8'hAA;
        @(negedge I_clk);
        I_rst = 1'b0;
        check_reset_vals("midline_reset");
        for (int b = 13; b < 24; b++) drive_byte(b, 2, 9, 1'b0);
        line_gap();
        check("no_partial_pixel", de_total, 98);
        check("queue_drained", exp_q.size(), 0);

        // Full skip again, then a 2047-byte line and a short frame
        vsync_pulse(1'b0);
        send_line(32, 0, 10, 1'b0);
        vsync_pulse(1'b0);
        vsync_pulse(1'b1);
        check("cnt_after_reskip", O_frame_cnt, 0);
        send_line(2047, 0, 11, 1'b1);
        check("odd_line_err", O_line_err, 1);
        check("no_frame_err_yet", O_frame_err, 0);
        send_line(32, 1, 11, 1'b1);
        vsync_pulse(1'b1);
        check("short_frame_err", O_frame_err, 1);
        check("cnt_short_frame", O_frame_cnt, 1);

        I_rst = 1'b1;
        repeat (2) @(negedge I_clk);
        I_rst = 1'b0;
        check("err_cleared_line", O_line_err, 0);
        check("err_cleared_frame", O_frame_err, 0);
        vsync_pulse(1'b0);
        vsync_pulse(1'b0);
        vsync_pulse(1'b1);
        send_line(20, 0, 12, 1'b1);
        check("short_line_err", O_line_err, 1);
        check("short_line_frame_err", O_frame_err, 0);

        repeat (4) @(negedge I_clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_pixel_total", de_total, 98);
        stim_done = 1'b1;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dvp_rgb565_capture.md
# dvp_rgb565_capture

Camera-side capture stage that sits directly upstream of the video frame buffer's write port. It samples the 8-bit DVP bus of the OV2640 (VSYNC, HREF, data) in the camera pixel-clock domain and pairs bytes into RGB565 pixels. It discards the first frames after reset, crops a programmable window, and emits frame-buffer-ready vs_n/de/data. It also counts captured frames and flags malformed lines or frames.

## Interface
Parameters:
- H_RES, 1024: output window width in pixels
- V_RES, 768: output window height in lines
- H_START, 0: first pixel column kept in each line
- V_START, 0: first line kept in each frame
- SKIP_FRAMES, 2: number of VSYNC active edges discarded after reset (camera settling)
- HI_FIRST, 1: 1 means the first byte of a pair is data[15:8]; 0 means it is data[7:0]
- VS_POL, 1: active level of I_vsync

Ports:
- I_clk  in  1  camera pixel clock (PIXCLK); the block's only clock
- I_rst  in  1  reset, synchronous, active-high
- I_enable  in  1  capture enable, sampled only at frame start
- I_vsync  in  1  camera VSYNC
- I_href  in  1  camera HREF, high during valid bytes
- I_data  in  8  camera data byte (PIXDATA[9:2])
- O_vs_n  out  1  frame sync to the frame buffer, active-low
- O_de  out  1  pixel-valid strobe, one cycle per pixel
- O_data  out  16  RGB565 pixel {r5,g6,b5}
- O_frame_cnt  out  16  number of completed captured frames, wraps
- O_line_err  out  1  sticky: bad line length seen
- O_frame_err  out  1  sticky: frame ended with too few lines

## Operation
- Input stage: I_vsync, I_href and I_data are registered once (d1). Edges are detected from d1 against d2. vsync_act = (vsync_d1 == VS_POL).
- State machine, reset state S_SKIP:
  - S_SKIP: count vsync_act rising edges. On reaching SKIP_FRAMES go to S_IDLE. SKIP_FRAMES = 0 goes to S_IDLE on the first cycle after reset.
  - S_IDLE: on a vsync_act rising edge with I_enable = 1, go to S_SYNC; otherwise stay.
  - S_SYNC: wait for vsync_act to fall, then clear x, y and phase and go to S_ACTIVE.
  - S_ACTIVE: on a vsync_act rising edge, the frame is complete:
    - O_frame_cnt increments.
    - If y < V_START+V_RES, set O_frame_err.
    - Go to S_SYNC if I_enable = 1, else S_IDLE.
- Byte pairing, in S_ACTIVE only:
  - phase toggles on each cycle with href_d1 = 1 and is forced to 0 while href_d1 = 0.
  - phase 0 latches the byte; phase 1 forms the pixel, with byte order set by HI_FIRST.
  - x (12 bit, saturates at 4095) increments after each formed pixel.
  - On the href_d1 falling edge, y (11 bit, saturates at 2047) increments and x clears.
- Crop: O_de = 1 on a formed pixel only when H_START ≤ x < H_START+H_RES and V_START ≤ y < V_START+V_RES. Other pixels are dropped. O_data updates only when O_de = 1.
- Line check: on the href_d1 falling edge in S_ACTIVE, set O_line_err if phase = 1 (odd byte count) or if x < H_START+H_RES.
- HREF pulses while in S_SYNC, S_IDLE or S_SKIP are ignored.
- O_vs_n = 0 exactly while in S_SYNC; it is 1 in all other states.
- Deasserting I_enable mid-frame does not truncate the frame; the block stops at the next frame boundary.

## Timing
- Reset values: O_vs_n = 1, O_de = 0, O_data = 0, O_frame_cnt = 0, both error flags 0, state S_SKIP, all counters 0.
- Reset asserted mid-frame aborts immediately. The next capture waits a full SKIP_FRAMES again.
- Latency: the second byte of a pair on I_data produces O_de/O_data 2 cycles later (input register, then output register). O_vs_n falls 2 cycles after the I_vsync active edge.
- O_de is at most one pulse every 2 cycles and is never high while O_vs_n = 0.
- A vsync edge and an href fall in the same cycle: frame completion takes priority and the line counts toward y first.
- O_frame_cnt updates in the same cycle O_vs_n goes low.
- Error flags clear only on reset.

## Structure
- Package video_cap_pkg holds:
  - the state enum (S_SKIP, S_IDLE, S_SYNC, S_ACTIVE)
  - X_W = 12, Y_W = 11
  - an rgb565 packed struct
- One sub-module, dvp_sync_edge: a 2-stage register for vsync/href that outputs level, rise and fall.

## Test plan
- Reset, then 3 synthetic frames of 1024×768 pixels, SKIP_FRAMES = 2 → frames 1–2 produce no O_de and O_vs_n stays 1. Frame 3 gives 786432 O_de pulses and O_frame_cnt = 1 at the start of frame 4.
- Bytes 0xF8, 0x1F with HI_FIRST = 1 → O_data = 0xF81F two cycles after the 0x1F byte. With HI_FIRST = 0 → O_data = 0x1FF8.
- Crop H_START = 4, H_RES = 8, V_START = 2, V_RES = 3, frame of 16×8 → exactly 24 O_de pulses, the first carrying pixel (4,2).
- A line of 2047 bytes → O_line_err = 1 after that line's href fall. A 700-line frame with V_RES = 768 → O_frame_err = 1.
- I_enable = 0 set halfway through frame 3 → frame 3 completes fully, then no O_de and O_vs_n stays 1. Re-enable → capture resumes at the next frame start.
- I_rst pulsed for 1 cycle mid-line → outputs return to reset values the next cycle and no partial pixel is emitted.
